dcache_resp_formatter: RTL and testbench

//  Consumer of data-cache responses, downstream of the dCache request interface and upstream of the mem_unit writeback.

---
 rtl/dcache_resp_formatter_pkg.sv | 21 ++
 rtl/dcache_resp_formatter_if.sv | 33 +++
 rtl/dcache_resp_formatter_align.sv | 36 +++
 rtl/dcache_resp_formatter.sv | 109 ++++++++++
 tb/tb_dcache_resp_formatter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dcache_resp_formatter_pkg.sv
// rtl/dcache_resp_formatter_pkg.sv - shared types and sizes for the dcache response formatter
package dcache_resp_formatter_pkg;

   localparam int NUM_TAGS = 128;
   localparam int TAG_W    = 7;
   localparam int DATA_W   = 64;
   localparam int CNT_W    = 8;

   typedef enum logic [1:0] {
      TAG_IDLE    = 2'd0,
      TAG_PENDING = 2'd1,
      TAG_KILLED  = 2'd2
   } tag_state_t;

   typedef struct packed {
      logic [3:0] size;
      logic [2:0] offset;
      logic       is_load;
   } rsp_meta_t;

endpackage

// File: rtl/dcache_resp_formatter_if.sv
// rtl/dcache_resp_formatter_if.sv - request/kill/response/writeback bundle for the formatter
interface dcache_resp_formatter_if;
   import dcache_resp_formatter_pkg::*;

   logic              req_fire_i;
   logic [TAG_W-1:0]  req_tag_i;
   logic [3:0]        req_size_i;
   logic [2:0]        req_offset_i;
   logic              req_is_load_i;
   logic              kill_i;
   logic              rsp_valid_i;
   logic [TAG_W-1:0]  rsp_tag_i;
   logic [DATA_W-1:0] rsp_rdata_i;
   logic              wb_valid_o;
   logic [TAG_W-1:0]  wb_tag_o;
   logic [DATA_W-1:0] wb_data_o;
   logic              wb_is_store_o;
   logic [CNT_W-1:0]  outstanding_o;
   logic              err_o;

   modport master (
      output req_fire_i, req_tag_i, req_size_i, req_offset_i, req_is_load_i,
      output kill_i, rsp_valid_i, rsp_tag_i, rsp_rdata_i,
      input  wb_valid_o, wb_tag_o, wb_data_o, wb_is_store_o, outstanding_o, err_o
   );

   modport slave (
      input  req_fire_i, req_tag_i, req_size_i, req_offset_i, req_is_load_i,
      input  kill_i, rsp_valid_i, rsp_tag_i, rsp_rdata_i,
      output wb_valid_o, wb_tag_o, wb_data_o, wb_is_store_o, outstanding_o, err_o
   );

endinterface

// File: rtl/dcache_resp_formatter_align.sv
// rtl/dcache_resp_formatter_align.sv - combinational byte-align and sign/zero extend of a load word
module dcache_load_align
   import dcache_resp_formatter_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [2:0]        size,
   input  logic [2:0]        offset,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] shifted;
   logic              sx;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      sx      = 1'b0;
      data    = shifted;
      // size[2] selects zero-extension; otherwise replicate the top bit of the access
      case (size[1:0])
         2'd0: begin
            sx   = ~size[2] & shifted[7];
            data = {{(DATA_W-8){sx}}, shifted[7:0]};
         end
         2'd1: begin
            sx   = ~size[2] & shifted[15];
            data = {{(DATA_W-16){sx}}, shifted[15:0]};
         end
         2'd2: begin
            sx   = ~size[2] & shifted[31];
            data = {{(DATA_W-32){sx}}, shifted[31:0]};
         end
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/dcache_resp_formatter.sv
// rtl/dcache_resp_formatter.sv - per-tag tracking of dcache requests and registered writeback formatting
module dcache_resp_formatter
   import dcache_resp_formatter_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rstn_i,
   dcache_resp_formatter_if.slave   bus
);

   tag_state_t        state_q [NUM_TAGS];
   tag_state_t        state_d [NUM_TAGS];
   rsp_meta_t         meta_q  [NUM_TAGS];
   tag_state_t        rsp_state;
   tag_state_t        req_state;
   logic              rsp_retire;
   logic              rsp_err;
   logic              wb_fire;
   logic              req_accept;
   logic              req_err;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W:0]    cnt_sum;
   logic              err_q;
   logic [DATA_W-1:0] aligned;
   logic [DATA_W-1:0] wb_data_d;
   logic              wb_valid_q;
   logic [TAG_W-1:0]  wb_tag_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              wb_is_store_q;

   always_comb begin
      rsp_state  = state_q[bus.rsp_tag_i];
      req_state  = state_q[bus.req_tag_i];
      rsp_retire = bus.rsp_valid_i && (rsp_state != TAG_IDLE);
      rsp_err    = bus.rsp_valid_i && (rsp_state == TAG_IDLE);
      wb_fire    = bus.rsp_valid_i && (rsp_state == TAG_PENDING) && !bus.kill_i;
      // a response retiring the same tag frees it for an issue in the same cycle
      req_accept = bus.req_fire_i &&
                   ((req_state == TAG_IDLE) || (rsp_retire && (bus.rsp_tag_i == bus.req_tag_i)));
      req_err    = bus.req_fire_i && !req_accept;
      cnt_sum    = {1'b0, cnt_q} + (CNT_W+1)'(req_accept) - (CNT_W+1)'(rsp_retire);
   end

   // later assignments take priority: kill, then retire, then new issue
   always_comb begin
      for (int i = 0; i < NUM_TAGS; i++) begin
         state_d[i] = state_q[i];
         if (bus.kill_i && (state_q[i] == TAG_PENDING))
            state_d[i] = TAG_KILLED;
         if (rsp_retire && (bus.rsp_tag_i == TAG_W'(i)))
            state_d[i] = TAG_IDLE;
         if (req_accept && (bus.req_tag_i == TAG_W'(i)))
            state_d[i] = TAG_PENDING;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            state_q[i] <= TAG_IDLE;
            meta_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TAGS; i++)
            state_q[i] <= state_d[i];
         if (req_accept)
            meta_q[bus.req_tag_i] <= '{size:    bus.req_size_i,
                                      offset:  bus.req_offset_i,
                                      is_load: bus.req_is_load_i};
      end
   end

   dcache_load_align u_align (
      .rdata  (bus.rsp_rdata_i),
      .size   (meta_q[bus.rsp_tag_i].size[2:0]),
      .offset (meta_q[bus.rsp_tag_i].offset),
      .data   (aligned)
   );

   assign wb_data_d = meta_q[bus.rsp_tag_i].is_load ? aligned : '0;

   // a carry/borrow out of the counter means the tag accounting broke
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q         <= '0;
         err_q         <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_tag_q      <= '0;
         wb_data_q     <= '0;
         wb_is_store_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_sum[CNT_W-1:0];
         err_q      <= err_q | rsp_err | req_err | cnt_sum[CNT_W];
         wb_valid_q <= wb_fire;
         if (wb_fire) begin
            wb_tag_q      <= bus.rsp_tag_i;
            wb_data_q     <= wb_data_d;
            wb_is_store_q <= ~meta_q[bus.rsp_tag_i].is_load;
         end
      end
   end

   assign bus.wb_valid_o    = wb_valid_q;
   assign bus.wb_tag_o      = wb_tag_q;
   assign bus.wb_data_o     = wb_data_q;
   assign bus.wb_is_store_o = wb_is_store_q;
   assign bus.outstanding_o = cnt_q;
   assign bus.err_o         = err_q;

endmodule

// File: tb/tb_dcache_resp_formatter.sv
// tb/tb_dcache_resp_formatter.sv - directed self-checking bench for dcache_resp_formatter
module tb_dcache_resp_formatter;
   import dcache_resp_formatter_pkg::*;

   logic clk_i = 1'b0;
   logic rstn_i = 1'b0;
   int   checks = 0;
   int   failures = 0;

   dcache_resp_formatter_if bus ();

   dcache_resp_formatter dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_fire_i    = 1'b0;
      bus.req_tag_i     = '0;
      bus.req_size_i    = '0;
      bus.req_offset_i  = '0;
      bus.req_is_load_i = 1'b0;
      bus.kill_i        = 1'b0;
      bus.rsp_valid_i   = 1'b0;
      bus.rsp_tag_i     = '0;
      bus.rsp_rdata_i   = '0;
   endtask

   task automatic set_req(input int tag, input logic [3:0] size, input logic [2:0] off, input logic ld);
      bus.req_fire_i    = 1'b1;
      bus.req_tag_i     = TAG_W'(tag);
      bus.req_size_i    = size;
      bus.req_offset_i  = off;
      bus.req_is_load_i = ld;
   endtask

   task automatic set_rsp(input int tag, input logic [63:0] rdata);
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tag_i   = TAG_W'(tag);
      bus.rsp_rdata_i = rdata;
   endtask

   task automatic issue(input int tag, input logic [3:0] size, input logic [2:0] off, input logic ld);
      set_req(tag, size, off, ld);
      step();
      clear_inputs();
   endtask

   task automatic respond(input int tag, input logic [63:0] rdata);
      set_rsp(tag, rdata);
      step();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      step();
      check("reset_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      check("reset_wb_data", bus.wb_data_o, 64'd0);
      check("reset_outstanding", 64'(bus.outstanding_o), 64'd0);
      check("reset_err", 64'(bus.err_o), 64'd0);
      rstn_i = 1'b1;
      step();

      // LB tag 5 offset 3
      issue(5, 4'd0, 3'd3, 1'b1);
      check("lb_outstanding", 64'(bus.outstanding_o), 64'd1);
      set_rsp(5, 64'h0000_0000_8000_0000);
      check("lb_no_early_wb", 64'(bus.wb_valid_o), 64'd0);
      step();
      clear_inputs();
      check("lb_wb_valid", 64'(bus.wb_valid_o), 64'd1);
      check("lb_wb_tag", 64'(bus.wb_tag_o), 64'd5);
      check("lb_wb_data", bus.wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_is_store", 64'(bus.wb_is_store_o), 64'd0);
      step();
      check("lb_pulse_end", 64'(bus.wb_valid_o), 64'd0);
      check("lb_data_hold", bus.wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);

      // LWU then LW, tag 9 offset 4
      issue(9, 4'b0110, 3'd4, 1'b1);
      respond(9, 64'h8765_4321_0000_0000);
      check("lwu_data", bus.wb_data_o, 64'h0000_0000_8765_4321);
      issue(9, 4'b0010, 3'd4, 1'b1);
      respond(9, 64'h8765_4321_0000_0000);
      check("lw_data", bus.wb_data_o, 64'hFFFF_FFFF_8765_4321);

      // flush of three pending tags
      issue(1, 4'd3, 3'd0, 1'b1);
      issue(2, 4'd3, 3'd0, 1'b1);
      issue(3, 4'd3, 3'd0, 1'b1);
      check("kill_outstanding3", 64'(bus.outstanding_o), 64'd3);
      bus.kill_i = 1'b1;
      step();
      clear_inputs();
      for (int t = 1; t <= 3; t++) begin
         respond(t, 64'h1234);
         check($sformatf("killed_rsp%0d_wb", t), 64'(bus.wb_valid_o), 64'd0);
      end
      check("kill_outstanding0", 64'(bus.outstanding_o), 64'd0);
      check("kill_err", 64'(bus.err_o), 64'd0);

      // response and re-issue of tag 7 in one cycle
      issue(7, 4'd3, 3'd0, 1'b1);
      set_rsp(7, 64'h1122_3344_5566_7788);
      set_req(7, 4'd0, 3'd1, 1'b1);
      step();
      clear_inputs();
      check("reissue_wb_valid", 64'(bus.wb_valid_o), 64'd1);
      check("reissue_wb_data", bus.wb_data_o, 64'h1122_3344_5566_7788);
      check("reissue_outstanding", 64'(bus.outstanding_o), 64'd1);
      check("reissue_err", 64'(bus.err_o), 64'd0);
      respond(7, 64'h0000_0000_0000_AB00);
      check("reissue_new_meta", bus.wb_data_o, 64'hFFFF_FFFF_FFFF_FFAB);
      check("reissue_outstanding0", 64'(bus.outstanding_o), 64'd0);

      // store
      issue(4, 4'd3, 3'd0, 1'b0);
      respond(4, 64'hDEAD_BEEF_DEAD_BEEF);
      check("store_wb_valid", 64'(bus.wb_valid_o), 64'd1);
      check("store_is_store", 64'(bus.wb_is_store_o), 64'd1);
      check("store_data", bus.wb_data_o, 64'd0);
      check("store_tag", 64'(bus.wb_tag_o), 64'd4);

      // kill and response on a pending tag in the same cycle
      issue(10, 4'd3, 3'd0, 1'b1);
      set_rsp(10, 64'h55);
      bus.kill_i = 1'b1;
      step();
      clear_inputs();
      check("killrsp_wb", 64'(bus.wb_valid_o), 64'd0);
      check("killrsp_outstanding", 64'(bus.outstanding_o), 64'd0);
      check("killrsp_err", 64'(bus.err_o), 64'd0);

      // fill every tag, then a duplicate issue
      for (int t = 0; t < NUM_TAGS; t++)
         issue(t, 4'd3, 3'd0, 1'b1);
      check("full_outstanding", 64'(bus.outstanding_o), 64'd128);
      check("full_err", 64'(bus.err_o), 64'd0);
      issue(0, 4'd0, 3'd0, 1'b1);
      check("dup_err", 64'(bus.err_o), 64'd1);
      check("dup_outstanding", 64'(bus.outstanding_o), 64'd128);
      respond(0, 64'h0123_4567_89AB_CDEF);
      check("dup_meta_kept", bus.wb_data_o, 64'h0123_4567_89AB_CDEF);
      check("pre_rst_wb_valid", 64'(bus.wb_valid_o), 64'd1);

      // asynchronous reset mid-burst
      set_rsp(1, 64'hFFFF);
      #2;
      rstn_i = 1'b0;
      #1;
      check("arst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      check("arst_wb_data", bus.wb_data_o, 64'd0);
      check("arst_wb_tag", 64'(bus.wb_tag_o), 64'd0);
      check("arst_outstanding", 64'(bus.outstanding_o), 64'd0);
      check("arst_err", 64'(bus.err_o), 64'd0);
      clear_inputs();
      step();
      rstn_i = 1'b1;
      step();
      respond(1, 64'hFFFF);
      check("idle_rsp_wb", 64'(bus.wb_valid_o), 64'd0);
      check("idle_rsp_err", 64'(bus.err_o), 64'd1);
      check("idle_rsp_outstanding", 64'(bus.outstanding_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
